alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//   Issue/writeback stage around the ALU. Accepts one operation per valid/ready handshake and holds
//   the operands stable on the ALU inputs until the ALU reports ready. Captures c and c_low, then
//   drives register-file write-back: one write for single-cycle ops, two for multiply/divide
//   (hi -> rd, lo -> rd+1). Stalls decode via in_ready while an operation is in flight.
// PARAMETERS
//   WIDTH     32  datapath width of operands and results
//   MAX_WAIT  64  watchdog limit in EXEC cycles (TIMEOUT_EN only)
// PORTS
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-low; all state cleared while low
//   in_valid   in   1      decode presents an op
//   in_ready   out  1      sequencer accepts the op (high only in IDLE)
//   in_funct   in   6      ALU function code
//   in_rd      in   5      destination register
//   in_a/in_b  in   WIDTH  operands
//   in_shamt   in   5      shift amount
//   alu_funct  out  6      latched funct to ALU (0 when IDLE)
//   alu_a/alu_b out WIDTH  latched operands to ALU
//   alu_shamt  out  5      latched shift amount
//   alu_run    out  1      high for every EXEC cycle; low restarts the ALU multi-cycle units
//   alu_c      in   WIDTH  ALU result / hi word
//   alu_c_low  in   WIDTH  ALU lo word (multiply low half, divide remainder)
//   alu_ready  in   1      ALU result valid
//   wb_en      out  1      register-file write strobe
//   wb_addr    out  5      write address
//   wb_data    out  WIDTH  write data
//   busy       out  1      state != IDLE
//   err        out  1      sticky timeout flag (constant 0 without TIMEOUT_EN)
// BEHAVIOUR
//   States: IDLE -> EXEC -> WB_HI -> (WB_LO if mul/div) -> IDLE.
//   Reset: state=IDLE. in_ready=1; all other outputs 0, including latched operand registers and err.
//   IDLE: in_ready=1. When in_valid is high at a clock edge, latch funct/rd/a/b/shamt and go to EXEC.
//   EXEC: alu_run=1; operands are held constant. Exit to WB_HI and capture alu_c -> hi_q and
//     alu_c_low -> lo_q on the first edge where alu_ready=1.
//     - mul/div (funct 6'h03/6'h04): alu_ready is ignored in the first EXEC cycle, so a stale ready
//       from the previous op is never taken.
//     - All other funct values: the op completes after exactly one EXEC cycle.
//   WB_HI: wb_addr=rd, wb_data=hi_q, wb_en=(rd!=0). Next state is WB_LO for mul/div, else IDLE.
//   WB_LO: wb_addr=rd+1, wb_data=lo_q, wb_en=(rd!=31); no wrap to r0. Next state IDLE.
//   Latency, accept edge to first wb_en: 2 cycles single-cycle op; N+1 for mul/div (N EXEC cycles).
//   Throughput: one single-cycle op per 3 cycles; in_ready is low in EXEC/WB_HI/WB_LO.
//   in_valid while busy: ignored and not latched; decode holds the op until in_ready.
//   Reset mid-op: immediate IDLE, no partial write-back, alu_run drops asynchronously.
// CONFIGURATION
//   ALU_SEQ_TIMEOUT_EN defined: a counter runs in EXEC. If MAX_WAIT cycles pass with no alu_ready:
//     set err (sticky until reset), go to IDLE, no write-back.
//   Undefined: no counter; err tied 0; EXEC waits indefinitely.
// STRUCTURE
//   Shared package alu_pkg: FUNCT_* constants (FUNCT_MUL=6'h03, FUNCT_DIV=6'h04, ...),
//     state enum typedef, is_multicycle(funct) function.
//   One sub-module alu_seq_watchdog (counter + compare), instantiated only under ALU_SEQ_TIMEOUT_EN.
// TESTING
//   1. add a=5 b=7 rd=3 -> EXEC 1 cycle; wb_en 2 cycles after accept, addr 3, data 12; one write.
//   2. mul a=0x10000 b=0x10000 rd=8, ready after 32 cycles -> wb r8=0x1, then r9=0x0; in_ready low throughout.
//   3. div a=17 b=5 rd=31 -> wb r31=3; no second write (rd=31); back to IDLE.
//   4. add with rd=0 -> wb_en stays 0; in_valid held during EXEC -> second op accepted only in next IDLE.
//   5. Reset low mid-mul (cycle 10 of EXEC) -> busy=0, alu_run=0, wb_en never pulses; next op completes normally.
//   6. TIMEOUT_EN, MAX_WAIT=64, alu_ready held 0 -> err=1 after 64 EXEC cycles, IDLE, no write.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer:
// function codes, sequencer state encoding and the multi-cycle op test.
package alu_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'h00;
    localparam logic [5:0] FUNCT_SUB = 6'h01;
    localparam logic [5:0] FUNCT_SLL = 6'h02;
    localparam logic [5:0] FUNCT_MUL = 6'h03;
    localparam logic [5:0] FUNCT_DIV = 6'h04;
    localparam logic [5:0] FUNCT_AND = 6'h05;
    localparam logic [5:0] FUNCT_OR  = 6'h06;
    localparam logic [5:0] FUNCT_XOR = 6'h07;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WB_HI = 2'd2,
        S_WB_LO = 2'd3
    } seq_state_e;

    function automatic logic is_multicycle(input logic [5:0] funct);
        return (funct == FUNCT_MUL) || (funct == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// EXEC-cycle watchdog: counts consecutive run cycles and flags the last
// allowed one. Only instantiated when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_watchdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;

    assign expired = run && (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around the ALU: holds operands until done, then
// writes hi (and lo for mul/div). Optional watchdog: ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shamt,
    output logic [5:0]       alu_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamt,
    output logic             alu_run,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [WIDTH-1:0] alu_c_low,
    input  logic             alu_ready,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             busy,
    output logic             err
);

    seq_state_e       state_q, state_d;
    logic [5:0]       funct_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [4:0]       shamt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             first_q;
    logic             accept, capture;
    logic             multi, ex_done, timeout;

    assign multi   = is_multicycle(funct_q);
    // A ready left over from the previous op must not finish a new mul/div.
    assign ex_done = multi ? (alu_ready && !first_q) : 1'b1;

    assign alu_funct = (state_q == S_IDLE) ? 6'd0 : funct_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_shamt = shamt_q;
    assign alu_run   = (state_q == S_EXEC);
    assign busy      = (state_q != S_IDLE);

`ifdef ALU_SEQ_TIMEOUT_EN
    logic err_q;

    alu_seq_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (alu_run),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (alu_run && !ex_done && timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            funct_q <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shamt_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= accept;
            if (accept) begin
                funct_q <= in_funct;
                rd_q    <= in_rd;
                a_q     <= in_a;
                b_q     <= in_b;
                shamt_q <= in_shamt;
            end
            if (capture) begin
                hi_q <= alu_c;
                lo_q <= alu_c_low;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        in_ready = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    capture = 1'b1;
                    state_d = S_WB_HI;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_WB_HI: begin
                wb_en   = (rd_q != 5'd0);
                wb_addr = rd_q;
                wb_data = hi_q;
                state_d = multi ? S_WB_LO : S_IDLE;
            end
            S_WB_LO: begin
                // rd=31 has no rd+1; suppress instead of wrapping to r0.
                wb_en   = (rd_q != 5'd31);
                wb_addr = rd_q + 5'd1;
                wb_data = lo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table plus hand sequences
// for hold-off, reset mid-op and (with ALU_SEQ_TIMEOUT_EN) the watchdog.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_rd, in_shamt;
    logic [31:0] in_a, in_b;
    logic [5:0]  alu_funct;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic        alu_run;
    logic [31:0] alu_c, alu_c_low;
    logic        alu_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy, err;

    alu_sequencer #(.WIDTH(32), .MAX_WAIT(64)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct  (in_funct),
        .in_rd     (in_rd),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_shamt  (in_shamt),
        .alu_funct (alu_funct),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shamt (alu_shamt),
        .alu_run   (alu_run),
        .alu_c     (alu_c),
        .alu_c_low (alu_c_low),
        .alu_ready (alu_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: combinational result, ready after mc_lat EXEC cycles
    // (mc_lat=0: ready stuck high; hold0: ready never comes).
    logic [63:0] prod;
    int          ex_cnt;
    int          mc_lat;
    bit          hold0;

    always_comb begin
        prod      = {32'b0, alu_a} * {32'b0, alu_b};
        alu_c     = '0;
        alu_c_low = '0;
        case (alu_funct)
            FUNCT_ADD: alu_c = alu_a + alu_b;
            FUNCT_SUB: alu_c = alu_a - alu_b;
            FUNCT_SLL: alu_c = alu_a << alu_shamt;
            FUNCT_XOR: alu_c = alu_a ^ alu_b;
            FUNCT_MUL: begin
                alu_c     = prod[63:32];
                alu_c_low = prod[31:0];
            end
            FUNCT_DIV: if (alu_b != 0) begin
                alu_c     = alu_a / alu_b;
                alu_c_low = alu_a % alu_b;
            end
            default: ;
        endcase
        alu_ready = hold0 ? 1'b0 :
                    (mc_lat == 0) ? 1'b1 :
                    (alu_run && (ex_cnt == mc_lat - 1));
    end

    always @(posedge clk) ex_cnt <= alu_run ? ex_cnt + 1 : 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          wr_n, first_wb, rdy_hi, cyc;
    bit          to;
    logic [4:0]  wr_a [4];
    logic [31:0] wr_d [4];

    // Called at a negedge; drives one op and returns at the negedge after accept.
    task automatic issue(input logic [5:0] f, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_funct = f;
        in_rd    = rd;
        in_a     = a;
        in_b     = b;
        in_shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Records writes until the sequencer is idle again; cyc 1 = first EXEC.
    task automatic track();
        wr_n     = 0;
        first_wb = 0;
        rdy_hi   = 0;
        cyc      = 1;
        to       = 1'b0;
        while (busy && cyc < 400) begin
            if (wb_en) begin
                if (wr_n < 4) begin
                    wr_a[wr_n] = wb_addr;
                    wr_d[wr_n] = wb_data;
                end
                if (first_wb == 0) first_wb = cyc;
                wr_n++;
            end
            if (in_ready) rdy_hi++;
            @(negedge clk);
            cyc++;
        end
        if (busy) to = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        int          lat;
        int          nwr;
        logic [4:0]  addr0;
        logic [31:0] d0;
        logic [4:0]  addr1;
        logic [31:0] d1;
        int          first;
    } vec_t;

    vec_t vt [7];

    initial begin
        int nrun;
        int wbseen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_funct = '0;
        in_rd    = '0;
        in_a     = '0;
        in_b     = '0;
        in_shamt = '0;
        hold0    = 1'b0;
        mc_lat   = 1;
        repeat (3) @(negedge clk);

        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_run", 32'(alu_run), 32'd0);
        chk("reset_funct", 32'(alu_funct), 32'd0);
        chk("reset_a", alu_a, 32'd0);
        chk("reset_wb_en", 32'(wb_en), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);

        vt[0] = '{"add", FUNCT_ADD, 5'd3, 32'd5, 32'd7, 5'd0, 1,
                  1, 5'd3, 32'd12, 5'd0, 32'd0, 2};
        vt[1] = '{"mul", FUNCT_MUL, 5'd8, 32'h10000, 32'h10000, 5'd0, 32,
                  2, 5'd8, 32'h1, 5'd9, 32'h0, 33};
        vt[2] = '{"div_r31", FUNCT_DIV, 5'd31, 32'd17, 32'd5, 5'd0, 8,
                  1, 5'd31, 32'd3, 5'd0, 32'd0, 9};
        vt[3] = '{"mul_stale", FUNCT_MUL, 5'd10, 32'd3, 32'd4, 5'd0, 0,
                  2, 5'd10, 32'd0, 5'd11, 32'd12, 3};
        vt[4] = '{"sub", FUNCT_SUB, 5'd4, 32'd5, 32'd7, 5'd0, 1,
                  1, 5'd4, 32'hFFFF_FFFE, 5'd0, 32'd0, 2};
        vt[5] = '{"sll", FUNCT_SLL, 5'd1, 32'd1, 32'd0, 5'd4, 1,
                  1, 5'd1, 32'd16, 5'd0, 32'd0, 2};
        vt[6] = '{"mul_r30", FUNCT_MUL, 5'd30, 32'hFFFF_FFFF, 32'd2, 5'd0, 5,
                  2, 5'd30, 32'h1, 5'd31, 32'hFFFF_FFFE, 6};

        for (int i = 0; i < 7; i++) begin
            mc_lat = vt[i].lat;
            issue(vt[i].funct, vt[i].rd, vt[i].a, vt[i].b, vt[i].sh);
            track();
            chk({vt[i].name, "_timeout"}, 32'(to), 32'd0);
            chk({vt[i].name, "_nwr"}, 32'(wr_n), 32'(vt[i].nwr));
            chk({vt[i].name, "_latency"}, 32'(first_wb), 32'(vt[i].first));
            chk({vt[i].name, "_in_ready_low"}, 32'(rdy_hi), 32'd0);
            if (wr_n > 0) begin
                chk({vt[i].name, "_addr0"}, 32'(wr_a[0]), 32'(vt[i].addr0));
                chk({vt[i].name, "_data0"}, wr_d[0], vt[i].d0);
            end
            if (vt[i].nwr > 1 && wr_n > 1) begin
                chk({vt[i].name, "_addr1"}, 32'(wr_a[1]), 32'(vt[i].addr1));
                chk({vt[i].name, "_data1"}, wr_d[1], vt[i].d1);
            end
        end

        // rd=0 suppresses the write; a second op held during EXEC waits.
        mc_lat   = 1;
        in_funct = FUNCT_ADD;
        in_rd    = 5'd0;
        in_a     = 32'd1;
        in_b     = 32'd2;
        in_shamt = '0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_rd = 5'd5;
        in_a  = 32'd100;
        in_b  = 32'd23;
        chk("hold_latched_a", alu_a, 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        track();
        chk("rd0_nwr", 32'(wr_n), 32'd0);
        chk("rd0_timeout", 32'(to), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("second_accept_busy", 32'(busy), 32'd1);
        track();
        chk("second_nwr", 32'(wr_n), 32'd1);
        chk("second_addr", 32'(wr_a[0]), 32'd5);
        chk("second_data", wr_d[0], 32'd123);
        chk("second_latency", 32'(first_wb), 32'd2);

        // Reset in the 10th EXEC cycle of a long multiply.
        mc_lat = 32;
        issue(FUNCT_MUL, 5'd8, 32'd6, 32'd7, 5'd0);
        repeat (9) @(negedge clk);
        chk("mid_run", 32'(alu_run), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_run", 32'(alu_run), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_funct", 32'(alu_funct), 32'd0);
        wbseen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wb_en) wbseen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wb_en) wbseen++;
        end
        chk("rst_no_wb", 32'(wbseen), 32'd0);
        mc_lat = 1;
        issue(FUNCT_ADD, 5'd7, 32'd40, 32'd2, 5'd0);
        track();
        chk("after_rst_nwr", 32'(wr_n), 32'd1);
        chk("after_rst_data", wr_d[0], 32'd42);
        chk("after_rst_addr", 32'(wr_a[0]), 32'd7);

`ifdef ALU_SEQ_TIMEOUT_EN
        hold0 = 1'b1;
        issue(FUNCT_MUL, 5'd12, 32'd3, 32'd3, 5'd0);
        nrun   = 0;
        wbseen = 0;
        cyc    = 1;
        while (busy && cyc < 400) begin
            if (alu_run) nrun++;
            if (wb_en) wbseen++;
            @(negedge clk);
            cyc++;
        end
        chk("wd_exec_cycles", 32'(nrun), 32'd64);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_no_wb", 32'(wbseen), 32'd0);
        hold0 = 1'b0;
        issue(FUNCT_XOR, 5'd2, 32'h0000_F0F0, 32'h0000_FFFF, 5'd0);
        track();
        chk("wd_err_sticky", 32'(err), 32'd1);
        chk("wd_next_data", wr_d[0], 32'h0000_0F0F);
`else
        nrun = 0;
        chk("err_tied_low", 32'(err), 32'(nrun));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
